// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU with valid/ready handshakes, internal flag register
//            and iterative STRMATCH / MULU / POPCNT operations.
// Revision : 1.0
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 8,
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag
);

    localparam int NPOS  = WIDTH - PAT_W + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_STR  = CNT_W'(NPOS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);
    localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] PAT_MASK  = {WIDTH{1'b1}} >> (WIDTH - PAT_W);

    localparam logic [3:0] OP_PASS     = 4'd0;
    localparam logic [3:0] OP_ABSDIFF  = 4'd1;
    localparam logic [3:0] OP_LSR1     = 4'd2;
    localparam logic [3:0] OP_ONE_LSL  = 4'd3;
    localparam logic [3:0] OP_MASK     = 4'd4;
    localparam logic [3:0] OP_STRMATCH = 4'd5;
    localparam logic [3:0] OP_ADDU     = 4'd6;
    localparam logic [3:0] OP_INC_IF_F = 4'd7;
    localparam logic [3:0] OP_SET_NEG  = 4'd8;
    localparam logic [3:0] OP_LSL1C    = 4'd9;
    localparam logic [3:0] OP_MIN      = 4'd10;
    localparam logic [3:0] OP_DEC_Z    = 4'd11;
    localparam logic [3:0] OP_DEC_ONE  = 4'd12;
    localparam logic [3:0] OP_ADD2     = 4'd13;
    localparam logic [3:0] OP_MULU     = 4'd14;
    localparam logic [3:0] OP_POPCNT   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 flag_q, flag_d;

    logic [WIDTH:0]       w_diff;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_onehot_a;
    logic [WIDTH-1:0]     w_sc_res;
    logic                 w_sc_flag;
    logic                 w_iter;
    logic                 w_accept;
    logic [WIDTH-1:0]     w_onehot_c;
    logic [WIDTH-1:0]     w_bsh;
    logic                 w_match;
    logic                 w_bit;
    logic [WIDTH-1:0]     w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod_nxt;
    logic                 w_last;

    // in_ready is held low while reset is asserted even though state is IDLE
    assign in_ready  = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign flag      = flag_q;
    assign w_accept  = in_valid & in_ready;

    assign w_diff     = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign w_sum      = {1'b0, a} + {1'b0, b};
    assign w_onehot_a = ONE << a;
    assign w_iter     = (op == OP_STRMATCH) | (op == OP_MULU) | (op == OP_POPCNT);

    always_comb begin
        w_sc_res  = a;
        w_sc_flag = flag_q;
        case (op)
            OP_PASS:     w_sc_res = a;
            OP_ABSDIFF:  w_sc_res = w_diff[WIDTH] ? (~w_diff[WIDTH-1:0] + ONE) : w_diff[WIDTH-1:0];
            OP_LSR1:     w_sc_res = a >> 1;
            OP_ONE_LSL:  w_sc_res = (a >= WIDTH_V) ? '0 : w_onehot_a;
            OP_MASK:     w_sc_res = (a >= WIDTH_V) ? '1 : (w_onehot_a - ONE);
            OP_ADDU:     {w_sc_flag, w_sc_res} = w_sum;
            OP_INC_IF_F: w_sc_res = a + WIDTH'(flag_q);
            OP_SET_NEG: begin
                w_sc_res  = a;
                w_sc_flag = a[WIDTH-1];
            end
            OP_LSL1C:    {w_sc_flag, w_sc_res} = {a, flag_q};
            OP_MIN:      w_sc_res = (a < b) ? a : b;
            OP_DEC_Z: begin
                w_sc_res  = a - ONE;
                w_sc_flag = (a == ONE);
            end
            OP_DEC_ONE: begin
                w_sc_res  = a - ONE;
                w_sc_flag = (a == TWO);
            end
            OP_ADD2:     w_sc_res = a + TWO;
            default:     ;
        endcase
    end

    // Per-iteration datapath; the STRMATCH window at position k is b[k+PAT_W-1:k]
    assign w_onehot_c = ONE << cnt_q;
    assign w_bsh      = b_q >> cnt_q;
    assign w_match    = ((w_bsh ^ a_q) & PAT_MASK) == '0;
    assign w_bit      = (op_q == OP_POPCNT) ? |(a_q & w_onehot_c) : w_match;
    assign w_acc_nxt  = acc_q + WIDTH'(w_bit);
    assign w_prod_nxt = prod_q + ((|(b_q & w_onehot_c)) ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
    assign w_last     = (cnt_q == ((op_q == OP_STRMATCH) ? LAST_STR : LAST_ITER));

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        result_d = result_q;
        flag_d   = flag_q;
        case (state_q)
            ST_RUN: begin
                cnt_d  = cnt_q + CNT_ONE;
                acc_d  = w_acc_nxt;
                prod_d = w_prod_nxt;
                if (w_last) begin
                    state_d = ST_DONE;
                    case (op_q)
                        OP_MULU: begin
                            result_d = w_prod_nxt[WIDTH-1:0];
                            flag_d   = |w_prod_nxt[2*WIDTH-1:WIDTH];
                        end
                        OP_STRMATCH: begin
                            result_d = w_acc_nxt;
                            flag_d   = |w_acc_nxt;
                        end
                        default: result_d = w_acc_nxt;
                    endcase
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: ;
        endcase
        // Accept is only possible from IDLE or a consumed DONE, so it overrides the above
        if (w_accept) begin
            op_d   = op;
            a_d    = a;
            b_d    = b;
            cnt_d  = '0;
            acc_d  = '0;
            prod_d = '0;
            if (w_iter) begin
                state_d = ST_RUN;
            end else begin
                state_d  = ST_DONE;
                result_d = w_sc_res;
                flag_d   = w_sc_flag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed self-checking bench for seq_alu (WIDTH=8, PAT_W=4).
// Revision : 1.0
// ============================================================================
module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       flag;

    int tests  = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       fl;
    } vec_t;

    vec_t vecs [17];

    seq_alu #(.WIDTH(8), .PAT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag)
    );

    always #5 clk = ~clk;

    // Presents a request and returns just after the edge that accepts it
    task automatic issue(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 in_valid = 1'b0;
        tests++;
        if (!ok) begin
            errors++;
            $display("FAIL issue_op%0d: in_ready stayed %b, required 1", o, in_ready);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({result, flag, out_valid, in_ready} !== 11'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h flag=%b ov=%b ir=%b, required 00 0 0 0",
                     result, flag, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_absdiff();
        int lat;
        issue(4'd1, 8'hFB, 8'h03);
        wait_done(lat);
        tests++;
        if (lat !== 1 || result !== 8'h08 || flag !== 1'b0) begin
            errors++;
            $display("FAIL absdiff: lat=%0d res=%h flag=%b, required 1 08 0", lat, result, flag);
        end
        consume();
    endtask

    task automatic test_addu_inc();
        int lat;
        issue(4'd6, 8'hF0, 8'h20);
        wait_done(lat);
        tests++;
        if (lat !== 1 || result !== 8'h10 || flag !== 1'b1) begin
            errors++;
            $display("FAIL addu: lat=%0d res=%h flag=%b, required 1 10 1", lat, result, flag);
        end
        consume();
        issue(4'd7, 8'h05, 8'h00);
        wait_done(lat);
        tests++;
        if (lat !== 1 || result !== 8'h06 || flag !== 1'b1) begin
            errors++;
            $display("FAIL inc_if_flag: lat=%0d res=%h flag=%b, required 1 06 1", lat, result, flag);
        end
        consume();
    endtask

    task automatic test_strmatch();
        int lat;
        issue(4'd5, 8'h05, 8'hAA);
        wait_done(lat);
        tests++;
        if (lat !== 6 || result !== 8'h02 || flag !== 1'b1) begin
            errors++;
            $display("FAIL strmatch_hit: lat=%0d res=%h flag=%b, required 6 02 1", lat, result, flag);
        end
        consume();
        issue(4'd5, 8'h0F, 8'h00);
        wait_done(lat);
        tests++;
        if (lat !== 6 || result !== 8'h00 || flag !== 1'b0) begin
            errors++;
            $display("FAIL strmatch_miss: lat=%0d res=%h flag=%b, required 6 00 0", lat, result, flag);
        end
        consume();
    endtask

    task automatic test_mulu_popcnt();
        int lat;
        issue(4'd14, 8'h13, 8'h11);
        wait_done(lat);
        tests++;
        if (lat !== 9 || result !== 8'h43 || flag !== 1'b1) begin
            errors++;
            $display("FAIL mulu: lat=%0d res=%h flag=%b, required 9 43 1", lat, result, flag);
        end
        consume();
        issue(4'd15, 8'hB7, 8'h00);
        wait_done(lat);
        tests++;
        if (lat !== 9 || result !== 8'h06 || flag !== 1'b1) begin
            errors++;
            $display("FAIL popcnt: lat=%0d res=%h flag=%b, required 9 06 1", lat, result, flag);
        end
        consume();
    endtask

    // Flag chains through the table in order: it enters this test as 1
    task automatic test_single_ops();
        int lat;
        vecs = '{
            '{4'd11, 8'h00, 8'h00, 8'hFF, 1'b0},
            '{4'd11, 8'h01, 8'h00, 8'h00, 1'b1},
            '{4'd13, 8'hFF, 8'h00, 8'h01, 1'b1},
            '{4'd3,  8'h08, 8'h00, 8'h00, 1'b1},
            '{4'd3,  8'h03, 8'h00, 8'h08, 1'b1},
            '{4'd4,  8'h09, 8'h00, 8'hFF, 1'b1},
            '{4'd4,  8'h03, 8'h00, 8'h07, 1'b1},
            '{4'd9,  8'h80, 8'h00, 8'h01, 1'b1},
            '{4'd9,  8'h01, 8'h00, 8'h03, 1'b0},
            '{4'd7,  8'h05, 8'h00, 8'h05, 1'b0},
            '{4'd8,  8'h85, 8'h00, 8'h85, 1'b1},
            '{4'd12, 8'h02, 8'h00, 8'h01, 1'b1},
            '{4'd12, 8'h03, 8'h00, 8'h02, 1'b0},
            '{4'd10, 8'h30, 8'h20, 8'h20, 1'b0},
            '{4'd1,  8'h03, 8'hFB, 8'h08, 1'b0},
            '{4'd2,  8'h81, 8'h00, 8'h40, 1'b0},
            '{4'd0,  8'h3C, 8'h55, 8'h3C, 1'b0}
        };
        for (int i = 0; i < 17; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            tests++;
            if (lat !== 1 || result !== vecs[i].res || flag !== vecs[i].fl) begin
                errors++;
                $display("FAIL single_op%0d_vec%0d: lat=%0d res=%h flag=%b, required 1 %h %b",
                         vecs[i].op, i, lat, result, flag, vecs[i].res, vecs[i].fl);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(4'd6, 8'hF0, 8'h20);
        wait_done(lat);
        op = 4'd2; a = 8'h81; b = 8'h00; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || result !== 8'h10 || flag !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold%0d: ov=%b res=%h flag=%b ir=%b, required 1 10 1 0",
                         i, out_valid, result, flag, in_ready);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 8'h40 || flag !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release: ov=%b res=%h flag=%b, required 1 40 1",
                     out_valid, result, flag);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(4'd11, 8'h05, 8'h00);
        wait_done(lat);
        consume();
        issue(4'd6, 8'hF0, 8'h20);
        wait_done(lat);
        @(negedge clk);
        op = 4'd7; a = 8'h05; b = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 8'h06 || flag !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_flag: ov=%b res=%h flag=%b, required 1 06 1",
                     out_valid, result, flag);
        end
        consume();
    endtask

    task automatic test_reset_midrun();
        int lat;
        issue(4'd14, 8'h13, 8'h11);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if (result !== 8'h00 || flag !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun: res=%h flag=%b ov=%b ir=%b, required 00 0 0 0",
                     result, flag, out_valid, in_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun_release: ir=%b ov=%b, required 1 0", in_ready, out_valid);
        end
        issue(4'd0, 8'h3C, 8'h00);
        wait_done(lat);
        tests++;
        if (lat !== 1 || result !== 8'h3C || flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_midrun_pass: lat=%0d res=%h flag=%b, required 1 3c 0", lat, result, flag);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_absdiff();
        test_addu_inc();
        test_strmatch();
        test_mulu_popcnt();
        test_single_ops();
        test_backpressure();
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit custom-ISA ALU.
- Keeps the same 16-op set and an architectural flag, now as an internal register instead of a flag-in/flag-out pair.
- Adds iterative ops (multi-position string match with count, multiply, popcount) and valid/ready handshakes on both sides.
- Sits between register-file read and writeback in the multi-cycle core.

Parameters:
WIDTH, 8, datapath width in bits; legal range >= 4.
PAT_W, 4, pattern width for STRMATCH; legal range 1 <= PAT_W <= WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request valid
in_ready  output  1  block can accept a request this cycle
op  input  4  opcode (encoding below)
a  input  WIDTH  operand A
b  input  WIDTH  operand B
out_valid  output  1  result/flag valid, held until consumed
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result
flag  output  1  architectural flag register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0, flag=0, out_valid=0, in_ready=0 while rst_n low. After release, in_ready=1 (IDLE).
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when in_valid & in_ready.
  - On accept, a, b, op and the current flag are latched; later input changes are ignored.
  - Single-cycle op: next state DONE.
  - Iterative op: next state RUN with counter=0.
- RUN: one iteration per cycle; after the last iteration, commit result/flag and go to DONE.
- DONE: out_valid=1; result and flag stable.
  - out_ready=1, no new accept: go to IDLE.
  - out_ready=1 with a new accept in the same cycle: go straight to RUN or DONE for the new op.
- Latency: single-cycle ops have out_valid high 1 cycle after the accept edge.
  - MULU, POPCNT: WIDTH+1 cycles after accept.
  - STRMATCH: NPOS+1 cycles, where NPOS = WIDTH-PAT_W+1.
- Flag commit: the flag register updates only on the edge entering DONE. Ops not listed as writing the flag leave it unchanged.
- "flag" in the op list below means the value latched at accept.
- Ops (unsigned unless noted; results truncated to WIDTH):
  - 0 PASS: result=A.
  - 1 ABSDIFF: signed |A-B|.
  - 2 LSR1: A>>1.
  - 3 ONE_LSL: 1<<A; A>=WIDTH gives 0.
  - 4 MASK: (1<<A)-1; A>=WIDTH gives all ones.
  - 5 STRMATCH (iterative): for k=0..NPOS-1, compare B[k+PAT_W-1:k] with A[PAT_W-1:0].
    - result = match count.
    - writes flag = (count != 0).
  - 6 ADDU: {flag,result}=A+B.
  - 7 INC_IF_FLAG: result=A+flag.
  - 8 SET_NEG: writes flag=A[WIDTH-1]; result=A.
  - 9 LSL1C: {flag,result}=(A<<1)+flag; the bit shifted out of A[WIDTH-1] goes to flag.
  - 10 MIN: min(A,B).
  - 11 DEC_Z: result=A-1; writes flag=(A==1).
  - 12 DEC_ONE: result=A-1; writes flag=(A==2).
  - 13 ADD2: result=A+2.
  - 14 MULU (iterative): shift-add over WIDTH iterations.
    - result = low WIDTH bits of the product.
    - writes flag = (high WIDTH bits != 0).
  - 15 POPCNT (iterative): one bit per cycle; result = number of ones in A.
- Wrap-around: A=0 with DEC_Z gives result all ones and flag=0. ADD2 wraps silently.
- Back-to-back: an op accepted in the same cycle DONE is consumed sees the flag value committed by the previous op.
- Reset mid-RUN: abandon the operation. Return to IDLE with result=0, flag=0 and no out_valid pulse.
- in_valid while busy (RUN, or DONE with out_ready=0) is not accepted. The requester must hold the request.

Test Plan (WIDTH=8, PAT_W=4):
- ABSDIFF a=0xFB, b=0x03 -> result 0x08, out_valid 1 cycle after accept, flag unchanged (0).
- ADDU a=0xF0, b=0x20 -> result 0x10, flag=1; then INC_IF_FLAG a=0x05 -> result 0x06, flag stays 1.
- STRMATCH a=0x05, b=0xAA -> matches at k=1 and k=3.
  - result 0x02, flag=1; out_valid exactly 6 cycles after accept.
  - a=0x0F, b=0x00 -> result 0, flag=0.
- MULU a=0x13, b=0x11 -> result 0x43, flag=1 (product 0x143), out_valid 9 cycles after accept.
  - POPCNT a=0xB7 -> result 0x06.
- Backpressure: hold out_ready=0 for 5 cycles after DONE.
  - result, flag and out_valid stable; in_ready=0.
  - Then out_ready=1 with in_valid=1 (LSR1 a=0x81): new op accepted that cycle; result 0x40 the next cycle.
- Reset: assert rst_n=0 at RUN iteration 4 of MULU -> result=0, flag=0, out_valid=0 immediately.
  - After release, in_ready=1; a following PASS a=0x3C returns 0x3C.
